// File: rtl/lzrw1_item_unpacker.sv
// LZRW1 item unpacker: strips the per-group control word and reassembles literal/copy
// items into 16-bit words plus a copy flag, with single-entry output register and backpressure.
module lzrw1_item_unpacker #(
  parameter int GROUP_ITEMS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] data_out,
  output logic        control_word_out,
  output logic        out_valid,
  output logic        item_last,
  input  logic        decompressor_busy,
  output logic        format_error
);

  typedef enum logic [1:0] {
    CTRL_LO = 2'd0,
    CTRL_HI = 2'd1,
    ITEM    = 2'd2,
    COPY_LO = 2'd3
  } state_t;

  localparam logic [3:0] IDX_LAST = 4'(GROUP_ITEMS - 1);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [15:0] ctrl_r, ctrl_s;
  logic [7:0]  hi_r, hi_s;
  logic [15:0] data_r, data_s;
  logic        copy_r, copy_s;
  logic        last_r, last_s;
  logic        valid_r, valid_s;
  logic        err_r, err_s;
  logic        emit_s;
  logic        ready_s;
  logic        accept_s;
  logic        consume_s;

  assign ready_s   = !valid_r || !decompressor_busy;
  assign accept_s  = in_valid && ready_s;
  assign consume_s = valid_r && !decompressor_busy;

  assign in_ready         = ready_s;
  assign data_out         = data_r;
  assign control_word_out = copy_r;
  assign out_valid        = valid_r;
  assign item_last        = last_r;
  assign format_error     = err_r;

  // Next-state decode: byte parsing, item emission and output-entry replacement
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    ctrl_s  = ctrl_r;
    hi_s    = hi_r;
    data_s  = data_r;
    copy_s  = copy_r;
    last_s  = last_r;
    valid_s = valid_r;
    err_s   = err_r;
    emit_s  = 1'b0;

    if (consume_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    if (accept_s) begin
      case (state_r)
        CTRL_LO: begin
          if (in_last) begin
            err_s = 1'b1;
          end else begin
            ctrl_s[7:0] = in_byte;
            state_s     = CTRL_HI;
          end
        end
        CTRL_HI: begin
          if (in_last) begin
            err_s   = 1'b1;
            state_s = CTRL_LO;
          end else begin
            ctrl_s[15:8] = in_byte;
            idx_s        = 4'd0;
            state_s      = ITEM;
          end
        end
        ITEM: begin
          if (ctrl_r[idx_r]) begin
            // A stream cannot end on the first half of a copy
            if (in_last) begin
              err_s   = 1'b1;
              idx_s   = 4'd0;
              state_s = CTRL_LO;
            end else begin
              hi_s    = in_byte;
              state_s = COPY_LO;
            end
          end else begin
            emit_s = 1'b1;
            data_s = {8'h00, in_byte};
            copy_s = 1'b0;
          end
        end
        COPY_LO: begin
          emit_s = 1'b1;
          data_s = {hi_r, in_byte};
          copy_s = 1'b1;
        end
        default: begin
          state_s = CTRL_LO;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end

    if (emit_s) begin
      valid_s = 1'b1;
      last_s  = in_last;
      if (in_last || (idx_r == IDX_LAST)) begin
        idx_s   = 4'd0;
        state_s = CTRL_LO;
      end else begin
        idx_s   = idx_r + 4'd1;
        state_s = ITEM;
      end
    end else begin
      last_s = last_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= CTRL_LO;
      idx_r   <= 4'd0;
      ctrl_r  <= 16'h0000;
      hi_r    <= 8'h00;
      data_r  <= 16'h0000;
      copy_r  <= 1'b0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ctrl_r  <= ctrl_s;
      hi_r    <= hi_s;
      data_r  <= data_s;
      copy_r  <= copy_s;
      last_r  <= last_s;
      valid_r <= valid_s;
      err_r   <= err_s;
    end
  end

endmodule

// File: tb/tb_lzrw1_item_unpacker.sv
// Directed self-checking bench for lzrw1_item_unpacker; inputs change #1 after the rising
// edge, outputs are sampled on the falling edge.
module tb_lzrw1_item_unpacker;

  logic        clock;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        out_valid;
  logic        item_last;
  logic        decompressor_busy;
  logic        format_error;

  int n_checks = 0;
  int n_fails  = 0;
  logic [17:0] items[$];

  lzrw1_item_unpacker #(.GROUP_ITEMS(16)) dut (
    .clock(clock),
    .reset(reset),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .data_out(data_out),
    .control_word_out(control_word_out),
    .out_valid(out_valid),
    .item_last(item_last),
    .decompressor_busy(decompressor_busy),
    .format_error(format_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every item as it is consumed downstream: {data, copy, last}
  always @(negedge clock) begin
    if (!reset && out_valid && !decompressor_busy) items.push_back({data_out, control_word_out, item_last});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte and hold it until accepted; returns #1 after the accepting edge
  task automatic send(input logic [7:0] b, input logic l);
    int n;
    in_byte = b; in_valid = 1'b1; in_last = l;
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n >= 100) begin
        n_checks++; n_fails++;
        $display("FAIL send_timeout: byte %h not accepted, required acceptance within 100 cycles", b);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; decompressor_busy = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (data_out !== 16'h0000) begin n_fails++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
    n_checks++; if (control_word_out !== 1'b0) begin n_fails++; $display("FAIL reset_copy: got %b want 0", control_word_out); end
    n_checks++; if (item_last !== 1'b0) begin n_fails++; $display("FAIL reset_item_last: got %b want 0", item_last); end
    n_checks++; if (format_error !== 1'b0) begin n_fails++; $display("FAIL reset_format_error: got %b want 0", format_error); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    items.delete();
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h30, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_no_item_on_copy_hi: out_valid got %b want 0", out_valid); end
    send(8'h05, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || data_out !== 16'h3005 || control_word_out !== 1'b1) begin
      n_fails++; $display("FAIL basic_copy_latency: got v=%b d=%h c=%b want v=1 d=3005 c=1", out_valid, data_out, control_word_out); end
    send(8'h41, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || data_out !== 16'h0041 || item_last !== 1'b1) begin
      n_fails++; $display("FAIL basic_literal_latency: got v=%b d=%h l=%b want v=1 d=0041 l=1", out_valid, data_out, item_last); end
    idle(2);
    n_checks++; if (items.size() !== 2) begin n_fails++; $display("FAIL basic_count: got %0d want 2", items.size()); end
    else begin
      n_checks++; if (items[0] !== {16'h3005, 1'b1, 1'b0}) begin n_fails++; $display("FAIL basic_item0: got %h want %h", items[0], {16'h3005, 1'b1, 1'b0}); end
      n_checks++; if (items[1] !== {16'h0041, 1'b0, 1'b1}) begin n_fails++; $display("FAIL basic_item1: got %h want %h", items[1], {16'h0041, 1'b0, 1'b1}); end
    end
    n_checks++; if (format_error !== 1'b0) begin n_fails++; $display("FAIL basic_format_error: got %b want 0", format_error); end
  endtask

  task automatic test_group_wrap();
    logic [17:0] exp;
    items.delete();
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    send(8'h12, 1'b0); send(8'h34, 1'b1);
    idle(2);
    n_checks++; if (items.size() !== 17) begin n_fails++; $display("FAIL wrap_count: got %0d want 17", items.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        exp = {8'h00, 8'(8'h10 + i), 1'b0, 1'b0};
        n_checks++; if (items[i] !== exp) begin n_fails++; $display("FAIL wrap_literal%0d: got %h want %h", i, items[i], exp); end
      end
      n_checks++; if (items[16] !== {16'h1234, 1'b1, 1'b1}) begin n_fails++; $display("FAIL wrap_copy: got %h want %h", items[16], {16'h1234, 1'b1, 1'b1}); end
    end
  endtask

  task automatic test_backpressure();
    items.delete();
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h30, 1'b0); send(8'h05, 1'b0);
    decompressor_busy = 1'b1;
    in_byte = 8'h41; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || data_out !== 16'h3005 || control_word_out !== 1'b1) begin
        n_fails++; $display("FAIL bp_hold%0d: got v=%b d=%h c=%b want v=1 d=3005 c=1", i, out_valid, data_out, control_word_out); end
      @(posedge clock); #1;
    end
    decompressor_busy = 1'b0;
    send(8'h41, 1'b1);
    idle(2);
    n_checks++; if (items.size() !== 2) begin n_fails++; $display("FAIL bp_count: got %0d want 2", items.size()); end
    else begin
      n_checks++; if (items[0] !== {16'h3005, 1'b1, 1'b0}) begin n_fails++; $display("FAIL bp_item0: got %h want %h", items[0], {16'h3005, 1'b1, 1'b0}); end
      n_checks++; if (items[1] !== {16'h0041, 1'b0, 1'b1}) begin n_fails++; $display("FAIL bp_item1: got %h want %h", items[1], {16'h0041, 1'b0, 1'b1}); end
    end
  endtask

  task automatic test_format_error();
    items.delete();
    send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h41, 1'b0); send(8'h30, 1'b1);
    n_checks++; if (format_error !== 1'b1) begin n_fails++; $display("FAIL fe_set: got %b want 1", format_error); end
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL fe_no_item: out_valid got %b want 0", out_valid); end
    idle(1);
    n_checks++; if (items.size() !== 1 || items[0] !== {16'h0041, 1'b0, 1'b0}) begin
      n_fails++; $display("FAIL fe_items: got n=%0d first=%h want n=1 first=%h", items.size(), items.size() > 0 ? items[0] : 18'h0, {16'h0041, 1'b0, 1'b0}); end
    items.delete();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h55, 1'b1);
    idle(2);
    n_checks++; if (items.size() !== 1 || items[0] !== {16'h0055, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL fe_recover: got n=%0d first=%h want n=1 first=%h", items.size(), items.size() > 0 ? items[0] : 18'h0, {16'h0055, 1'b0, 1'b1}); end
    n_checks++; if (format_error !== 1'b1) begin n_fails++; $display("FAIL fe_sticky: got %b want 1", format_error); end
  endtask

  task automatic test_mid_reset();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h77, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
    n_checks++; if (format_error !== 1'b0) begin n_fails++; $display("FAIL mr_format_error: got %b want 0", format_error); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL mr_in_ready: got %b want 1", in_ready); end
    @(posedge clock); #1;
    items.delete();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h55, 1'b1);
    idle(2);
    n_checks++; if (items.size() !== 1 || items[0] !== {16'h0055, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL mr_stream: got n=%0d first=%h want n=1 first=%h", items.size(), items.size() > 0 ? items[0] : 18'h0, {16'h0055, 1'b0, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_group_wrap();
    test_backpressure();
    test_format_error();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lzrw1_item_unpacker.md
Name: lzrw1_item_unpacker

Overview:
- Upstream neighbour of the decompressor core. Accepts the LZRW1 compressed byte stream one byte per cycle.
- Strips the 16-bit control word that heads every group of 16 items.
- Reassembles each item (1-byte literal or 2-byte copy) into a 16-bit word with a 1-bit control flag, in the form the decompressor consumes.
- Honours the decompressor's busy signal as backpressure.

Parameters:
GROUP_ITEMS, 16, items per control-word group; must equal the control-word bit count (16). Any other value is illegal.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_byte  input  8  compressed stream byte
in_valid  input  1  in_byte is valid this cycle
in_last  input  1  in_byte is the final byte of the compressed stream
in_ready  output  1  block accepts in_byte this cycle; a transfer occurs when in_valid && in_ready
data_out  output  16  assembled item; literal = {8'h00, byte}; copy = {first byte, second byte}
control_word_out  output  1  0 = literal, 1 = copy item
out_valid  output  1  data_out / control_word_out / item_last valid
item_last  output  1  this item is the final item of the stream
decompressor_busy  input  1  downstream busy; an item is consumed when out_valid && !decompressor_busy
format_error  output  1  sticky; stream ended mid-control-word or mid-copy-item

Behaviour:
- Reset (synchronous, clock edge with reset=1): state=CTRL_LO, item index=0, ctrl shift reg=0, out_valid=0, data_out=0, control_word_out=0, item_last=0, format_error=0. in_ready is 1 on the first cycle after reset. Reset mid-stream discards all partial state, including any held output item.
- Output register: single entry. in_ready = !out_valid || !decompressor_busy, so one byte per cycle is sustained when downstream is not busy.
- Consume rule: the entry clears on the cycle it is consumed unless a new item completes in the same cycle; in that case the new item overwrites it with no bubble.
- Output stability: while out_valid && decompressor_busy, all outputs hold stable.
- States:
  - CTRL_LO: accepted byte -> ctrl[7:0]; go to CTRL_HI.
  - CTRL_HI: accepted byte -> ctrl[15:8]; item index=0; go to ITEM.
  - ITEM, ctrl[index]=0: accepted byte emits a literal. Latency: out_valid rises the cycle after the byte is accepted.
  - ITEM, ctrl[index]=1: accepted byte is latched as the copy high byte; go to COPY_LO.
  - COPY_LO: accepted byte completes the copy {hi, byte}; item is emitted; return to ITEM.
- Bit order: control word is little-endian. Item i uses ctrl bit i; bit 0 is the first item after the control word.
- Group wrap: after item index 15 completes (index wraps to 0), go to CTRL_LO.
- A group can end early only via in_last.
- in_last on a literal or a completed copy byte:
  - emitted item has item_last=1;
  - state returns to CTRL_LO, index=0, ready for a new stream.
- in_last while in CTRL_LO, CTRL_HI, or on the first byte of a copy (ITEM with ctrl bit=1):
  - format_error set (cleared only by reset);
  - partial data discarded, no item emitted;
  - state returns to CTRL_LO.
- in_last with in_valid=0 is ignored. Bytes are never accepted while in_ready=0, and no state advances on such cycles.

Test Plan:
- Bytes 0x01,0x00,0x30,0x05,0x41 (last on 0x41), busy=0 -> items {0x3005,copy=1,last=0}, {0x0041,copy=0,last=1}. Each item has out_valid for one cycle, the cycle after its final byte is accepted. format_error=0.
- Control 0x00,0x00 then 16 literals 0x10..0x1F, then control 0xFF,0xFF and copy 0x12,0x34 -> 16 literals 0x0010..0x001F with copy=0, followed by {0x1234, copy=1}. Confirms group wrap and CTRL_LO re-entry.
- Same as first scenario but busy=1 for 3 cycles while 0x3005 is valid -> data_out holds 0x3005, in_ready=0 for those 3 cycles, and byte 0x41 is not taken until busy=0. No item is lost or duplicated.
- Control 0x02,0x00, literal 0x41, copy first byte 0x30 with in_last=1 -> one item 0x0041 emitted; format_error=1 the next cycle; state back to CTRL_LO. A subsequent valid stream still decodes correctly with format_error still 1.
- Assert reset for one cycle after CTRL_LO/CTRL_HI and one literal -> out_valid=0, format_error=0, in_ready=1. A new stream 0x00,0x00,0x55(last) yields {0x0055, copy=0, last=1}.
